spike_rate_decoder: RTL and testbench

Receiving end of the LIF neuron's spike output. Converts a one-bit spike train back into numbers.
- Rate: spike count per fixed window.
- ISI (optional): inter-spike interval, cycles between consecutive spikes.
Sits beside the neuron inside the top-level wrapper; its outputs drive the uio/uo pins for on-chip observation of neuron activity.

---
 rtl/spike_dec_pkg.sv | 32 +++
 rtl/spike_isi_timer.sv | 80 ++++++++
 rtl/spike_rate_decoder.sv | 135 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_dec_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : spike_dec_pkg                                          |
// | Shared state encodings, default widths and a small sizing helper |
// | for the spike rate / inter-spike-interval decoder.               |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package spike_dec_pkg;

  // Window FSM: idle or counting spikes inside a window
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } win_state_t;

  // ISI timer: waiting for the first spike, or timing the gap to the next
  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } isi_state_t;

  localparam int WINDOW_CYCLES_DEF = 256;
  localparam int COUNT_W_DEF       = 8;
  localparam int ISI_W_DEF         = 8;

  // Bits needed to hold a window position 0..cycles-1 (never below 1)
  function automatic int win_ctr_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage : spike_dec_pkg
`default_nettype wire

// File: rtl/spike_isi_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : spike_isi_timer                                        |
// | Measures cycles between consecutive spike events, saturating at  |
// | 2^ISI_W-1. Only compiled when SPIKE_DEC_ISI_EN is defined.       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`ifdef SPIKE_DEC_ISI_EN
module spike_isi_timer
  import spike_dec_pkg::*;
#(
  parameter int ISI_W = ISI_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,        // window FSM not counting: restart
  input  logic             spike_event,  // one-cycle rising-edge strobe
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid
);

  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  isi_state_t       state, state_nxt;
  logic [ISI_W-1:0] isi_ctr, isi_ctr_nxt;
  logic [ISI_W-1:0] isi_nxt;
  logic             isi_valid_nxt;

  // Timer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_FIRST;
      isi_ctr   <= '0;
      isi       <= '0;
      isi_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      isi_ctr   <= isi_ctr_nxt;
      isi       <= isi_nxt;
      isi_valid <= isi_valid_nxt;
    end
  end

  // Next state: first spike arms the counter, each later spike publishes it
  always_comb begin
    state_nxt     = state;
    isi_ctr_nxt   = isi_ctr;
    isi_nxt       = isi;
    isi_valid_nxt = 1'b0;
    if (clear) begin
      state_nxt   = WAIT_FIRST;
      isi_ctr_nxt = '0;
    end else begin
      case (state)
        WAIT_FIRST: begin
          if (spike_event) begin
            state_nxt   = MEASURE;
            isi_ctr_nxt = ISI_W'(1);
          end
        end
        MEASURE: begin
          if (spike_event) begin
            isi_nxt       = isi_ctr;
            isi_valid_nxt = 1'b1;
            isi_ctr_nxt   = ISI_W'(1);
          end else if (isi_ctr != ISI_MAX) begin
            isi_ctr_nxt = isi_ctr + ISI_W'(1);
          end
        end
        default: begin
          state_nxt   = WAIT_FIRST;
          isi_ctr_nxt = '0;
        end
      endcase
    end
  end

endmodule : spike_isi_timer
`endif
`default_nettype wire

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : spike_rate_decoder                                     |
// | Converts a one-bit spike train into a per-window spike count and |
// | (with SPIKE_DEC_ISI_EN defined) the inter-spike interval.        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int COUNT_W       = COUNT_W_DEF,
  parameter int ISI_W         = ISI_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               spike_in,
  output logic [COUNT_W-1:0] rate,
  output logic               rate_valid,
  output logic [ISI_W-1:0]   isi,
  output logic               isi_valid,
  output logic               busy
);

  localparam int                 WIN_W     = win_ctr_width(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  win_state_t         state, state_nxt;
  logic               spike_prev;
  logic               spike_event;
  logic [WIN_W-1:0]   window_ctr, window_ctr_nxt;
  logic [COUNT_W-1:0] spike_ctr, spike_ctr_nxt;
  logic [COUNT_W-1:0] spike_ctr_inc;
  logic [COUNT_W-1:0] rate_nxt;
  logic               rate_valid_nxt;

  // A held-high level is one event: only the 0->1 transition counts
  assign spike_event   = spike_in & ~spike_prev;
  assign spike_ctr_inc = (spike_ctr == COUNT_MAX) ? COUNT_MAX : spike_ctr + COUNT_W'(1);
  assign busy          = (state == COUNT);

  // Previous-cycle spike level, tracked in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_prev <= 1'b0;
    end else begin
      spike_prev <= spike_in;
    end
  end

  // Window FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Window counters and published rate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_ctr <= '0;
      spike_ctr  <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
    end else begin
      window_ctr <= window_ctr_nxt;
      spike_ctr  <= spike_ctr_nxt;
      rate       <= rate_nxt;
      rate_valid <= rate_valid_nxt;
    end
  end

  // Next state: the closing cycle's own event is folded into the result
  always_comb begin
    state_nxt      = state;
    window_ctr_nxt = window_ctr;
    spike_ctr_nxt  = spike_ctr;
    rate_nxt       = rate;
    rate_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt      = COUNT;
          window_ctr_nxt = '0;
          spike_ctr_nxt  = '0;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (window_ctr == WIN_LAST) begin
          rate_nxt       = spike_event ? spike_ctr_inc : spike_ctr;
          rate_valid_nxt = 1'b1;
          window_ctr_nxt = '0;
          spike_ctr_nxt  = '0;
        end else begin
          window_ctr_nxt = window_ctr + WIN_W'(1);
          if (spike_event) begin
            spike_ctr_nxt = spike_ctr_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef SPIKE_DEC_ISI_EN
  logic isi_clear;

  // Interval timing runs only while a window is being counted
  assign isi_clear = (state != COUNT);

  spike_isi_timer #(
    .ISI_W (ISI_W)
  ) u_isi_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (isi_clear),
    .spike_event (spike_event),
    .isi         (isi),
    .isi_valid   (isi_valid)
  );
`else
  assign isi       = '0;
  assign isi_valid = 1'b0;
`endif

endmodule : spike_rate_decoder
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_spike_rate_decoder                                  |
// | Self-checking bench: a 16-cycle and a 512-cycle decoder share    |
// | stimulus and are compared against an event-level reference.     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_spike_rate_decoder;

  localparam int W0      = 16;
  localparam int W1      = 512;
  localparam int MAX_CNT = 255;
  localparam int MAX_ISI = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic spike_in = 1'b0;

  logic [7:0] rate_a, rate_b, isi_a, isi_b;
  logic       rv_a, rv_b, iv_a, iv_b, busy_a, busy_b;

  int n_assert = 0;
  int n_fail   = 0;
  int t        = 0;

  // Reference state: one entry per DUT
  int m_busy[2], m_pos[2], m_cnt[2], m_rate[2], m_rv[2];
  int m_isi[2], m_iv[2], m_have[2], m_last[2];
  int m_prev;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW_CYCLES(W0), .COUNT_W(8), .ISI_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
    .rate(rate_a), .rate_valid(rv_a), .isi(isi_a), .isi_valid(iv_a), .busy(busy_a)
  );

  spike_rate_decoder #(.WINDOW_CYCLES(W1), .COUNT_W(8), .ISI_W(8)) dut_long (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
    .rate(rate_b), .rate_valid(rv_b), .isi(isi_b), .isi_valid(iv_b), .busy(busy_b)
  );

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_pos[k] = 0; m_cnt[k] = 0; m_rate[k] = 0; m_rv[k] = 0;
      m_isi[k] = 0; m_iv[k] = 0; m_have[k] = 0; m_last[k] = 0;
    end
  endtask

  // Reference behaviour for one clock edge, in terms of events and windows
  task automatic model_edge();
    int ev;
    int w;
    ev = (spike_in && !m_prev) ? 1 : 0;
    m_prev = spike_in ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? W0 : W1;
      m_rv[k] = 0;
      m_iv[k] = 0;
      if (m_busy[k] != 0) begin
        if (ev != 0) begin
          if (m_have[k] != 0) begin
            m_isi[k] = min_i(t - m_last[k], MAX_ISI);
            m_iv[k]  = 1;
          end
          m_have[k] = 1;
          m_last[k] = t;
        end
      end else begin
        m_have[k] = 0;
      end
      if (m_busy[k] == 0) begin
        if (enable) begin
          m_busy[k] = 1; m_pos[k] = 0; m_cnt[k] = 0;
        end
      end else if (!enable) begin
        m_busy[k] = 0;
      end else begin
        m_cnt[k] += ev;
        if (m_pos[k] == w - 1) begin
          m_rate[k] = min_i(m_cnt[k], MAX_CNT);
          m_rv[k]   = 1;
          m_pos[k]  = 0;
          m_cnt[k]  = 0;
        end else begin
          m_pos[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    int ei, ev;
    for (int k = 0; k < 2; k++) begin
`ifdef SPIKE_DEC_ISI_EN
      ei = m_isi[k]; ev = m_iv[k];
`else
      ei = 0; ev = 0;
`endif
      chk($sformatf("rate[%0d]@%0d", k, t), (k == 0) ? rate_a : rate_b, m_rate[k]);
      chk($sformatf("rate_valid[%0d]@%0d", k, t), (k == 0) ? rv_a : rv_b, m_rv[k]);
      chk($sformatf("busy[%0d]@%0d", k, t), (k == 0) ? busy_a : busy_b, m_busy[k]);
      chk($sformatf("isi[%0d]@%0d", k, t), (k == 0) ? isi_a : isi_b, ei);
      chk($sformatf("isi_valid[%0d]@%0d", k, t), (k == 0) ? iv_a : iv_b, ev);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_all();
    t++;
  endtask

  // Drive one 16-cycle window on the short decoder and check its result
  task automatic run_window(input logic [15:0] pat, input int exp_rate, input string tag);
    for (int k = 0; k < 16; k++) begin
      spike_in = pat[k];
      step();
    end
    chk({tag, "_valid"}, rv_a, 1);
    chk({tag, "_rate"}, rate_a, exp_rate);
  endtask

  initial begin
    int n;
    int ei;
    model_reset();
    // Reset state
    step();
    step();
    chk("reset_rate", rate_a, 0);
    chk("reset_busy", busy_a, 0);
    rst_n = 1'b1;

    // Five single-cycle spikes, then an empty window
    enable = 1'b1;
    step();
    run_window(16'h4924, 5, "five_spikes");
    run_window(16'h0000, 0, "empty_window");

    // Held level counts once; boundary events land in the right window
    run_window(16'h047E, 2, "held_level");
    run_window(16'h8000, 1, "last_cycle_event");
    run_window(16'h0000, 0, "after_last_cycle");
    run_window(16'h0001, 1, "first_cycle_event");

    // Drop enable at window cycle 9 after three events
    for (int k = 0; k < 10; k++) begin
      spike_in = (k == 1 || k == 3 || k == 5);
      enable   = (k != 9);
      step();
    end
    chk("disable_busy", busy_a, 0);
    chk("disable_no_valid", rv_a, 0);
    chk("disable_rate_hold", rate_a, 1);
    for (int k = 0; k < 5; k++) begin
      spike_in = ($urandom_range(0, 1) == 1);
      step();
    end
    spike_in = 1'b0;
    step();
    enable   = 1'b1;
    spike_in = 1'b1;
    step();
    run_window(16'h0014, 2, "reenable_fresh");

    // Randomized activity with occasional enable drops
    for (int k = 0; k < 1500; k++) begin
      enable   = ($urandom_range(0, 19) != 0);
      spike_in = ($urandom_range(0, 2) == 0);
      step();
    end
    enable = 1'b1;

    // Asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rate", rate_a, 0);
    chk("async_busy", busy_a, 0);
    check_all();
    @(negedge clk);
    step();
    rst_n    = 1'b1;
    spike_in = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!rv_a && n < 40);
    chk("first_valid_latency", n, 17);

    // Saturation on the 512-cycle decoder
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    spike_in = 1'b0;
    step();
    for (int k = 0; k < 512; k++) begin
      spike_in = (k % 2 == 0);
      step();
    end
    chk("sat_valid", rv_b, 1);
    chk("sat_rate", rate_b, 255);

    // Inter-spike interval: normal and saturated
    rst_n = 1'b0;
    spike_in = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int c = 0; c < 320; c++) begin
      spike_in = (c == 3 || c == 10 || c == 310);
      step();
      if (c == 10 || c == 310) begin
`ifdef SPIKE_DEC_ISI_EN
        ei = (c == 10) ? 7 : 255;
        chk("isi_valid_pulse", iv_a, 1);
`else
        ei = 0;
        chk("isi_valid_tied", iv_a, 0);
`endif
        chk("isi_value", isi_a, ei);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_spike_rate_decoder
`default_nettype wire
